// File: rtl/spi_bus_arbiter.sv
// Two-master round-robin arbiter and SPI frame sequencer for the shared RAM/ROM bus.
// One 84-cycle frame per grant; SPI pins are registered from the current phase.
//
// state    | meaning
// ST_IDLE  | ph = 0, arbitrating on every edge
// ST_FRAME | ph = 1..83, shifting one frame out/in
module spi_bus_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic        rnw0,
  input  logic        rnw1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        spi_cs0,
  output logic        spi_cs1,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  localparam logic [6:0] PH_LAST = 7'd83;

  state_t      r_state;
  logic [6:0]  r_ph;
  logic        r_gnt;
  logic        r_last;
  logic        r_sel;
  logic        r_rnw;
  logic [14:0] r_addr_sh;
  logic [15:0] r_wdata_sh;
  logic [15:0] r_rd_sh;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_win;
  logic        w_grant;
  logic [15:0] w_addr_sel;
  logic [15:0] w_wdata_sel;
  logic        w_rnw_sel;
  logic        w_active;
  logic        w_cs0_nxt;
  logic        w_cs1_nxt;
  logic        w_clk_nxt;
  logic        w_mosi_nxt;

  // A master whose ack is high this cycle sits out, so the other one gets the next frame.
  assign w_elig0     = req0 & ~ack0;
  assign w_elig1     = req1 & ~ack1;
  assign w_win       = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  assign w_grant     = (r_state == ST_IDLE) & (w_elig0 | w_elig1);
  assign w_addr_sel  = w_win ? addr1 : addr0;
  assign w_wdata_sel = w_win ? wdata1 : wdata0;
  assign w_rnw_sel   = w_win ? rnw1 : rnw0;

  assign w_active  = (r_ph >= 7'd2);
  assign w_cs0_nxt = w_active ? r_sel : 1'b1;
  assign w_cs1_nxt = w_active ? ~r_sel : 1'b1;
  assign w_clk_nxt = (r_ph >= 7'd2 && r_ph <= 7'd81) ? r_ph[0] : 1'b0;

  always_comb begin
    w_mosi_nxt = 1'b0;
    if (r_ph >= 7'd14 && r_ph <= 7'd15)
      w_mosi_nxt = 1'b1;
    else if (r_ph >= 7'd16 && r_ph <= 7'd17)
      w_mosi_nxt = r_rnw;
    else if (r_ph >= 7'd18 && r_ph <= 7'd47)
      w_mosi_nxt = r_addr_sh[0];
    else if (r_ph >= 7'd50 && r_ph <= 7'd81)
      w_mosi_nxt = ~r_rnw & r_wdata_sh[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ph       <= 7'd0;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
      r_rnw      <= 1'b0;
      r_addr_sh  <= 15'd0;
      r_wdata_sh <= 16'd0;
      r_rd_sh    <= 16'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= 16'd0;
      busy       <= 1'b0;
      spi_cs0    <= 1'b1;
      spi_cs1    <= 1'b1;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      spi_cs0  <= w_cs0_nxt;
      spi_cs1  <= w_cs1_nxt;
      spi_clk  <= w_clk_nxt;
      spi_mosi <= w_mosi_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state    <= ST_FRAME;
            r_ph       <= 7'd1;
            busy       <= 1'b1;
            r_gnt      <= w_win;
            r_last     <= w_win;
            r_sel      <= w_addr_sel[15];
            r_addr_sh  <= w_addr_sel[14:0];
            r_wdata_sh <= w_wdata_sel;
            r_rnw      <= w_rnw_sel;
          end
        end
        ST_FRAME: begin
          // Each serial bit is held for an even/odd phase pair; advance after the odd one.
          if (r_ph[0] && r_ph >= 7'd19 && r_ph <= 7'd47)
            r_addr_sh <= {1'b0, r_addr_sh[14:1]};
          if (r_ph[0] && r_ph >= 7'd51 && r_ph <= 7'd81)
            r_wdata_sh <= {1'b0, r_wdata_sh[15:1]};
          if (!r_ph[0] && r_ph >= 7'd52 && r_ph <= 7'd82)
            r_rd_sh <= {spi_miso, r_rd_sh[15:1]};
          if (r_ph == PH_LAST) begin
            r_state <= ST_IDLE;
            r_ph    <= 7'd0;
            busy    <= 1'b0;
            if (r_gnt)
              ack1 <= 1'b1;
            else
              ack0 <= 1'b1;
            if (r_rnw)
              rdata <= r_rd_sh;
          end else begin
            r_ph <= r_ph + 7'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: reads, writes, contention, withdrawal,
// streaming and mid-frame reset, with a phase-tracked memory model on MISO.
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, rnw0, rnw1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata;
  logic        spi_cs0, spi_cs1, spi_clk, spi_mosi, spi_miso;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  spi_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .rnw0(rnw0), .rnw1(rnw1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .spi_cs0(spi_cs0), .spi_cs1(spi_cs1),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_mosi(input int q, input logic [15:0] a, input logic r,
                                    input logic [15:0] w);
    if (q >= 14 && q <= 15) return 1'b1;
    if (q >= 16 && q <= 17) return r;
    if (q >= 18 && q <= 47) return a[(q - 18) / 2];
    if (q >= 50 && q <= 81) return r ? 1'b0 : w[(q - 50) / 2];
    return 1'b0;
  endfunction

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 300);
  endtask

  // Entered in the first frame cycle (ph = 1); returns in the ack cycle.
  task automatic run_frame(input logic [15:0] a, input logic r, input logic [15:0] w,
                           input logic [15:0] mem, input int drop_p, input string tag,
                           output logic got0, output logic got1);
    logic [83:0] mo, c0, c1, ck, e_mo, e_c0, e_c1, e_ck;
    logic busy_ok, early, overlap;
    busy_ok = 1'b1;
    early   = 1'b0;
    overlap = 1'b0;
    for (int p = 1; p <= 84; p++) begin
      if (p > 1) @(negedge clk);
      mo[p-1]   = spi_mosi;
      c0[p-1]   = spi_cs0;
      c1[p-1]   = spi_cs1;
      ck[p-1]   = spi_clk;
      e_mo[p-1] = exp_mosi(p - 1, a, r, w);
      e_c0[p-1] = (p - 1 >= 2) ? a[15] : 1'b1;
      e_c1[p-1] = (p - 1 >= 2) ? ~a[15] : 1'b1;
      e_ck[p-1] = (p - 1 >= 2 && p - 1 <= 81) ? ((p - 1) % 2 == 1) : 1'b0;
      if (p <= 83 && busy !== 1'b1) busy_ok = 1'b0;
      if (p == 84 && busy !== 1'b0) busy_ok = 1'b0;
      if (p <= 83 && (ack0 !== 1'b0 || ack1 !== 1'b0)) early = 1'b1;
      if (ack0 === 1'b1 && ack1 === 1'b1) overlap = 1'b1;
      spi_miso = (p >= 52 && p <= 82 && p % 2 == 0) ? mem[(p - 52) / 2] : 1'b0;
      if (p == drop_p) req0 = 1'b0;
    end
    got0 = ack0;
    got1 = ack1;
    chk({tag, " mosi"}, mo, e_mo);
    chk({tag, " cs0"}, c0, e_c0);
    chk({tag, " cs1"}, c1, e_c1);
    chk({tag, " sclk"}, ck, e_ck);
    chk({tag, " busy window"}, 84'(busy_ok), 84'(1));
    chk({tag, " early ack"}, 84'(early), 84'(0));
    chk({tag, " ack overlap"}, 84'(overlap), 84'(0));
  endtask

  initial begin
    int n;
    logic g0, g1, idle_ok;
    logic [15:0] s_mem [3];
    s_mem[0] = 16'h0F0F;
    s_mem[1] = 16'hF0F0;
    s_mem[2] = 16'h3C3C;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rnw0 = 1'b1; rnw1 = 1'b1;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0; spi_miso = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst cs0", 84'(spi_cs0), 84'(1));
    chk("rst cs1", 84'(spi_cs1), 84'(1));
    chk("rst sclk", 84'(spi_clk), 84'(0));
    chk("rst mosi", 84'(spi_mosi), 84'(0));
    chk("rst ack0", 84'(ack0), 84'(0));
    chk("rst ack1", 84'(ack1), 84'(0));
    chk("rst rdata", 84'(rdata), 84'(16'h0000));
    chk("rst busy", 84'(busy), 84'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // single read from RAM
    addr0 = 16'h0005; rnw0 = 1'b1; req0 = 1'b1;
    wait_grant(n);
    chk("rd grant latency", 84'(n), 84'(1));
    run_frame(16'h0005, 1'b1, 16'h0, 16'hA5C3, 0, "rd", g0, g1);
    chk("rd ack0", 84'(g0), 84'(1));
    chk("rd ack1", 84'(g1), 84'(0));
    chk("rd rdata", 84'(rdata), 84'(16'hA5C3));
    req0 = 1'b0;
    @(negedge clk);
    chk("rd ack0 one cycle", 84'(ack0), 84'(0));
    chk("rd idle busy", 84'(busy), 84'(0));

    // write to ROM half
    addr1 = 16'h8003; rnw1 = 1'b0; wdata1 = 16'h1234; req1 = 1'b1;
    wait_grant(n);
    chk("wr grant latency", 84'(n), 84'(1));
    run_frame(16'h8003, 1'b0, 16'h1234, 16'hFFFF, 0, "wr", g0, g1);
    chk("wr ack1", 84'(g1), 84'(1));
    chk("wr ack0", 84'(g0), 84'(0));
    chk("wr rdata held", 84'(rdata), 84'(16'hA5C3));
    req1 = 1'b0;
    @(negedge clk);

    // contention straight after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    addr0 = 16'h0010; rnw0 = 1'b1; addr1 = 16'h0020; rnw1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    wait_grant(n);
    chk("ct first grant", 84'(n), 84'(1));
    run_frame(16'h0010, 1'b1, 16'h0, 16'h1111, 0, "ct0", g0, g1);
    chk("ct0 ack0", 84'(g0), 84'(1));
    chk("ct0 rdata", 84'(rdata), 84'(16'h1111));
    wait_grant(n);
    chk("ct spacing 0->1", 84'(83 + n), 84'(84));
    run_frame(16'h0020, 1'b1, 16'h0, 16'h2222, 0, "ct1", g0, g1);
    chk("ct1 ack1", 84'(g1), 84'(1));
    chk("ct1 rdata", 84'(rdata), 84'(16'h2222));
    wait_grant(n);
    chk("ct spacing 1->0", 84'(83 + n), 84'(84));
    run_frame(16'h0010, 1'b1, 16'h0, 16'h3333, 0, "ct2", g0, g1);
    chk("ct2 ack0", 84'(g0), 84'(1));
    chk("ct2 rdata", 84'(rdata), 84'(16'h3333));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // request withdrawn mid-frame
    addr0 = 16'h0042; rnw0 = 1'b1; req0 = 1'b1;
    wait_grant(n);
    chk("wd grant latency", 84'(n), 84'(1));
    run_frame(16'h0042, 1'b1, 16'h0, 16'h5A5A, 30, "wd", g0, g1);
    chk("wd ack0", 84'(g0), 84'(1));
    chk("wd rdata", 84'(rdata), 84'(16'h5A5A));
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || spi_cs0 !== 1'b1 || spi_cs1 !== 1'b1 || spi_clk !== 1'b0 ||
          spi_mosi !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0)
        idle_ok = 1'b0;
    end
    chk("wd stays idle", 84'(idle_ok), 84'(1));

    // same-master streaming
    addr0 = 16'h0100; rnw0 = 1'b1; req0 = 1'b1;
    wait_grant(n);
    chk("st grant latency", 84'(n), 84'(1));
    for (int k = 0; k < 3; k++) begin
      run_frame(16'h0100 + 16'(k), 1'b1, 16'h0, s_mem[k], 0, "st", g0, g1);
      chk("st ack0", 84'(g0), 84'(1));
      chk("st rdata", 84'(rdata), 84'(s_mem[k]));
      if (k < 2) begin
        addr0 = 16'h0101 + 16'(k);
        wait_grant(n);
        chk("st ack-to-grant gap", 84'(n), 84'(2));
        chk("st period", 84'(83 + n), 84'(85));
      end
    end
    req0 = 1'b0;
    @(negedge clk);

    // reset in the middle of a write frame
    addr0 = 16'h0007; rnw0 = 1'b0; wdata0 = 16'hBEEF; req0 = 1'b1;
    wait_grant(n);
    chk("rs grant latency", 84'(n), 84'(1));
    repeat (59) @(negedge clk);
    chk("rs cs0 active at ph60", 84'(spi_cs0), 84'(0));
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rs cs0 async", 84'(spi_cs0), 84'(1));
    chk("rs cs1 async", 84'(spi_cs1), 84'(1));
    chk("rs busy async", 84'(busy), 84'(0));
    chk("rs sclk async", 84'(spi_clk), 84'(0));
    repeat (2) @(negedge clk);
    chk("rs no ack0", 84'(ack0), 84'(0));
    chk("rs no ack1", 84'(ack1), 84'(0));
    chk("rs rdata cleared", 84'(rdata), 84'(16'h0000));
    rst_n = 1'b1;
    @(negedge clk);
    addr0 = 16'h0003; rnw0 = 1'b1; req0 = 1'b1;
    wait_grant(n);
    chk("rs fresh grant", 84'(n), 84'(1));
    run_frame(16'h0003, 1'b1, 16'h0, 16'h0A0A, 0, "rs", g0, g1);
    chk("rs ack0", 84'(g0), 84'(1));
    chk("rs rdata", 84'(rdata), 84'(16'h0A0A));
    req0 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
